// File: rtl/axis_coincidence_reader_if.sv
// AXI-Stream event bus used by axis_coincidence_reader.
// Carries {timestamp, accumulated hits} beats with a valid/ready handshake.
interface axis_coincidence_reader_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_coincidence_reader.sv
// axis_coincidence_reader: opens a coincidence window on the first hit seen at
// the delayed tap, ORs hits across the window, counts fired channel groups and
// emits one timestamped AXI-Stream beat when the count reaches the threshold.
// Samples with a nonzero tap that arrive while a window is being evaluated,
// sent or in dead time are counted in sts_lost (saturating).
// Optional build macro: AXIS_COINCIDENCE_READER_GROUP_MASK_EN adds cfg_mask,
// a per-group mask (1 = group ignored) latched at window open.
module axis_coincidence_reader #(
    parameter int DET_WIDTH   = 64,
    parameter int GROUP_WIDTH = 16,
    parameter int TIME_WIDTH  = 64,
    parameter int DELAY       = 4,
    parameter int CNTR_WIDTH  = 8,
    localparam int GROUPS     = DET_WIDTH / GROUP_WIDTH,
    localparam int THR_WIDTH  = $clog2(GROUPS + 1)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DET_WIDTH-1:0]   det_data,
    input  logic [CNTR_WIDTH-1:0]  cfg_window,
    input  logic [THR_WIDTH-1:0]   cfg_threshold,
    input  logic [CNTR_WIDTH-1:0]  cfg_deadtime,
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
    input  logic [GROUPS-1:0]      cfg_mask,
`endif
    axis_coincidence_reader_if.master m_axis,
    output logic [31:0]            sts_lost
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_GROUP = 3'd2,
        S_SUM   = 3'd3,
        S_CMP   = 3'd4,
        S_SEND  = 3'd5,
        S_DEAD  = 3'd6
    } state_t;

    // Per-group OR reduction of a hit vector.
    function automatic logic [GROUPS-1:0] group_or(input logic [DET_WIDTH-1:0] v);
        logic [GROUPS-1:0] g;
        g = '0;
        for (int i = 0; i < GROUPS; i++) begin
            g[i] = |v[i*GROUP_WIDTH +: GROUP_WIDTH];
        end
        return g;
    endfunction

    // Number of set bits in the fired-group vector.
    function automatic logic [THR_WIDTH-1:0] pop_count(input logic [GROUPS-1:0] v);
        logic [THR_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < GROUPS; i++) begin
            c = c + THR_WIDTH'(v[i]);
        end
        return c;
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [DET_WIDTH-1:0]    pipe_r [DELAY];
    logic [DET_WIDTH-1:0]    tap_s;
    logic                    tap_hit_s;
    logic [TIME_WIDTH-1:0]   time_r;
    logic [DET_WIDTH-1:0]    acc_r;
    logic [TIME_WIDTH-1:0]   ts_r;
    logic [CNTR_WIDTH-1:0]   wcnt_r;
    logic [CNTR_WIDTH-1:0]   dcnt_r;
    logic [CNTR_WIDTH-1:0]   dead_r;
    logic [THR_WIDTH-1:0]    thr_r;
    logic [GROUPS-1:0]       grp_r;
    logic [GROUPS-1:0]       group_keep_s;
    logic [THR_WIDTH-1:0]    sum_r;
    logic                    emit_s;
    logic                    lost_state_s;
    logic [TIME_WIDTH+DET_WIDTH-1:0] tdata_r;
    logic                    tvalid_r;
    logic [31:0]             sts_lost_r;

`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
    logic [GROUPS-1:0]       mask_r;
    assign group_keep_s = ~mask_r;
`else
    assign group_keep_s = {GROUPS{1'b1}};
`endif

    assign tap_s        = pipe_r[DELAY-1];
    assign tap_hit_s    = |tap_s;
    assign emit_s       = (sum_r >= thr_r);
    assign lost_state_s = (state_r == S_GROUP) || (state_r == S_SUM) ||
                          (state_r == S_CMP)   || (state_r == S_SEND) ||
                          (state_r == S_DEAD);

    assign m_axis.tdata  = tdata_r;
    assign m_axis.tvalid = tvalid_r;
    assign sts_lost      = sts_lost_r;

    // Input delay line; its last stage is the trigger tap.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= det_data;
            for (int i = 1; i < DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Free-running time base, 0 in the first cycle after reset release.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            time_r <= '0;
        end else begin
            time_r <= time_r + TIME_WIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (tap_hit_s) begin
                    if (cfg_window != '0) begin
                        state_nx_s = S_ACCUM;
                    end else begin
                        state_nx_s = S_GROUP;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (wcnt_r == CNTR_WIDTH'(1)) begin
                    state_nx_s = S_GROUP;
                end else begin
                    state_nx_s = S_ACCUM;
                end
            end
            S_GROUP: state_nx_s = S_SUM;
            S_SUM:   state_nx_s = S_CMP;
            S_CMP: begin
                if (emit_s) begin
                    state_nx_s = S_SEND;
                end else if (dead_r != '0) begin
                    state_nx_s = S_DEAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (!m_axis.tready) begin
                    state_nx_s = S_SEND;
                end else if (dead_r != '0) begin
                    state_nx_s = S_DEAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_DEAD: begin
                if (dcnt_r == CNTR_WIDTH'(1)) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DEAD;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Window datapath: capture/accumulate hits, group reduce, popcount, counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_r  <= '0;
            ts_r   <= '0;
            wcnt_r <= '0;
            dcnt_r <= '0;
            dead_r <= '0;
            thr_r  <= '0;
            grp_r  <= '0;
            sum_r  <= '0;
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
            mask_r <= '0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (tap_hit_s) begin
                        acc_r  <= tap_s;
                        ts_r   <= time_r - TIME_WIDTH'(DELAY);
                        wcnt_r <= cfg_window;
                        thr_r  <= cfg_threshold;
                        dead_r <= cfg_deadtime;
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
                        mask_r <= cfg_mask;
`endif
                    end
                end
                S_ACCUM: begin
                    acc_r  <= acc_r | tap_s;
                    wcnt_r <= wcnt_r - CNTR_WIDTH'(1);
                end
                S_GROUP: grp_r  <= group_or(acc_r) & group_keep_s;
                S_SUM:   sum_r  <= pop_count(grp_r);
                S_CMP:   dcnt_r <= dead_r;
                S_DEAD:  dcnt_r <= dcnt_r - CNTR_WIDTH'(1);
                default: begin
                end
            endcase
        end
    end

    // Output beat registers; tvalid follows entry into and exit from SEND.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
        end else begin
            tvalid_r <= (state_nx_s == S_SEND);
            if ((state_r == S_CMP) && emit_s) begin
                tdata_r <= {ts_r, acc_r};
            end
        end
    end

    // Saturating count of hit samples that arrive while no window can take them.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sts_lost_r <= '0;
        end else if (lost_state_s && tap_hit_s && (sts_lost_r != 32'hFFFF_FFFF)) begin
            sts_lost_r <= sts_lost_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Directed bench for axis_coincidence_reader (default parameters: 4 groups of
// 16 channels, DELAY=4). Cycle 0 is the first cycle with aresetn high; its
// time counter value is 0.
module tb_axis_coincidence_reader;

    logic        aclk;
    logic        aresetn;
    logic [63:0] det_data;
    logic [7:0]  cfg_window;
    logic [2:0]  cfg_threshold;
    logic [7:0]  cfg_deadtime;
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
    logic [3:0]  cfg_mask;
`endif
    logic [31:0] sts_lost;

    axis_coincidence_reader_if #(.DATA_WIDTH(128)) axis_bus ();

    axis_coincidence_reader dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .det_data      (det_data),
        .cfg_window    (cfg_window),
        .cfg_threshold (cfg_threshold),
        .cfg_deadtime  (cfg_deadtime),
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
        .cfg_mask      (cfg_mask),
`endif
        .m_axis        (axis_bus),
        .sts_lost      (sts_lost)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0]  w;
        logic [2:0]  thr;
        logic [7:0]  d;
        logic [3:0]  mask;
        logic [63:0] h0; int c0;
        logic [63:0] h1; int c1;
        logic [63:0] h2; int c2;
        logic [63:0] h3; int c3;
        logic        exp_emit;
        int          exp_cyc;
        logic [63:0] exp_ts;
        logic [63:0] exp_acc;
        logic [31:0] exp_lost;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        det_data = 64'd0;
        axis_bus.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc = 0;
    endtask

    function automatic vec_t mk(input logic [7:0] w, input logic [2:0] thr, input logic [3:0] mask,
                                input logic [63:0] h0, input int c0, input logic [63:0] h1, input int c1,
                                input logic [63:0] h2, input int c2, input logic [63:0] h3, input int c3,
                                input logic emit, input int ecyc, input logic [63:0] ts,
                                input logic [63:0] acc, input logic [31:0] lost);
        vec_t v;
        v.w = w; v.thr = thr; v.d = 8'd0; v.mask = mask;
        v.h0 = h0; v.c0 = c0; v.h1 = h1; v.c1 = c1;
        v.h2 = h2; v.c2 = c2; v.h3 = h3; v.c3 = c3;
        v.exp_emit = emit; v.exp_cyc = ecyc; v.exp_ts = ts; v.exp_acc = acc; v.exp_lost = lost;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int beats;
        int first_cyc;
        logic [127:0] first_data;
        reset_dut();
        cfg_window    = v.w;
        cfg_threshold = v.thr;
        cfg_deadtime  = v.d;
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
        cfg_mask      = v.mask;
`endif
        beats = 0;
        first_cyc = -1;
        first_data = '0;
        for (int c = 0; c < 48; c++) begin
            if (axis_bus.tvalid === 1'b1) begin
                if (beats == 0) begin
                    first_cyc  = c;
                    first_data = axis_bus.tdata;
                end
                beats++;
            end
            det_data = 64'd0;
            if (c == v.c0) det_data = det_data | v.h0;
            if (c == v.c1) det_data = det_data | v.h1;
            if (c == v.c2) det_data = det_data | v.h2;
            if (c == v.c3) det_data = det_data | v.h3;
            step();
        end
        check($sformatf("vec%0d_beats", idx), 128'(beats), v.exp_emit ? 128'd1 : 128'd0);
        if (v.exp_emit) begin
            check($sformatf("vec%0d_tvalid_cycle", idx), 128'(first_cyc), 128'(v.exp_cyc));
            check($sformatf("vec%0d_tdata", idx), first_data, {v.exp_ts, v.exp_acc});
        end
        check($sformatf("vec%0d_lost", idx), 128'(sts_lost), 128'(v.exp_lost));
    endtask

    initial begin
        int beats;
        int beat_cyc [4];
        logic [127:0] beat_data [4];
        int first_cyc;
        logic [127:0] first_data;

        aresetn = 1'b0;
        det_data = 64'd0;
        cfg_window = 8'd0;
        cfg_threshold = 3'd0;
        cfg_deadtime = 8'd0;
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
        cfg_mask = 4'd0;
`endif
        axis_bus.tready = 1'b1;

        // Reset state
        reset_dut();
        check("reset_tvalid", 128'(axis_bus.tvalid), 128'd0);
        check("reset_tdata", axis_bus.tdata, 128'd0);
        check("reset_lost", 128'(sts_lost), 128'd0);

        // w, thr, mask, hits (data, cycle) x4, emit, tvalid cycle, ts, acc, lost
        vecs.push_back(mk(8'd3, 3'd2, 4'd0, 64'h1, 10, 64'h0001_0000_0000_0000, 12, 64'd0, -1, 64'd0, -1,
                          1'b1, 21, 64'd10, 64'h0001_0000_0000_0001, 32'd0));
        vecs.push_back(mk(8'd3, 3'd3, 4'd0, 64'h1, 10, 64'h0001_0000_0000_0000, 12,
                          64'h0000_0001_0001_0001, 22, 64'd0, -1,
                          1'b1, 33, 64'd22, 64'h0000_0001_0001_0001, 32'd0));
        vecs.push_back(mk(8'd0, 3'd0, 4'd0, 64'h8000, 5, 64'd0, -1, 64'd0, -1, 64'd0, -1,
                          1'b1, 13, 64'd5, 64'h8000, 32'd0));
        vecs.push_back(mk(8'd2, 3'd4, 4'd0, 64'h1, 10, 64'h1_0000, 11, 64'h1_0000_0000, 12,
                          64'h1000_0000_0000_0000, 13, 1'b0, 0, 64'd0, 64'd0, 32'd1));
        vecs.push_back(mk(8'd3, 3'd4, 4'd0, 64'h1, 10, 64'h1_0000, 11, 64'h1_0000_0000, 12,
                          64'h1000_0000_0000_0000, 13, 1'b1, 21, 64'd10, 64'h1000_0001_0001_0001, 32'd0));
        vecs.push_back(mk(8'd3, 3'd5, 4'd0, 64'h1, 10, 64'h1_0000, 11, 64'h1_0000_0000, 12,
                          64'h1000_0000_0000_0000, 13, 1'b0, 0, 64'd0, 64'd0, 32'd0));
        vecs.push_back(mk(8'd0, 3'd1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'd0, -1, 64'd0, -1, 64'd0, -1,
                          1'b1, 11, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0));
`ifdef AXIS_COINCIDENCE_READER_GROUP_MASK_EN
        vecs.push_back(mk(8'd1, 3'd2, 4'b0001, 64'h1_0001, 5, 64'd0, -1, 64'd0, -1, 64'd0, -1,
                          1'b0, 0, 64'd0, 64'd0, 32'd0));
        vecs.push_back(mk(8'd1, 3'd2, 4'b0000, 64'h1_0001, 5, 64'd0, -1, 64'd0, -1, 64'd0, -1,
                          1'b1, 14, 64'd5, 64'h1_0001, 32'd0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: tvalid/tdata hold while tready is low; tap hits in SEND are lost
        reset_dut();
        cfg_window = 8'd0; cfg_threshold = 3'd1; cfg_deadtime = 8'd0;
        axis_bus.tready = 1'b0;
        for (int c = 0; c < 41; c++) begin
            if (c == 12) check("bp_tvalid_before", 128'(axis_bus.tvalid), 128'd0);
            if (c >= 13 && c <= 33)
                check($sformatf("bp_hold_c%0d", c), {axis_bus.tvalid, axis_bus.tdata},
                      {1'b1, 64'd5, 64'h1});
            if (c == 34) check("bp_tvalid_after", 128'(axis_bus.tvalid), 128'd0);
            det_data = (c == 5) ? 64'h1 : ((c >= 6 && c <= 28) ? 64'h2 : 64'd0);
            axis_bus.tready = (c >= 33);
            step();
        end
        check("bp_lost", 128'(sts_lost), 128'd23);

        // Dead time with continuous hits
        reset_dut();
        cfg_window = 8'd0; cfg_threshold = 3'd1; cfg_deadtime = 8'd5;
        beats = 0;
        for (int c = 0; c < 45; c++) begin
            if (axis_bus.tvalid === 1'b1) begin
                if (beats < 4) begin
                    beat_cyc[beats]  = c;
                    beat_data[beats] = axis_bus.tdata;
                end
                beats++;
            end
            if (c == 19) check("dead_lost_first_window", 128'(sts_lost), 128'd9);
            det_data = (c >= 5 && c <= 30) ? 64'h4 : 64'd0;
            step();
        end
        check("dead_beats", 128'(beats), 128'd3);
        if (beats == 3) begin
            check("dead_beat0_cyc", 128'(beat_cyc[0]), 128'd13);
            check("dead_beat1_cyc", 128'(beat_cyc[1]), 128'd23);
            check("dead_beat2_cyc", 128'(beat_cyc[2]), 128'd33);
            check("dead_beat0_data", beat_data[0], {64'd5, 64'h4});
            check("dead_beat1_data", beat_data[1], {64'd15, 64'h4});
            check("dead_beat2_data", beat_data[2], {64'd25, 64'h4});
        end
        check("dead_lost_total", 128'(sts_lost), 128'd23);

        // Reset during ACCUM drops the event and restarts the time base
        reset_dut();
        cfg_window = 8'd10; cfg_threshold = 3'd0; cfg_deadtime = 8'd0;
        for (int c = 0; c < 12; c++) begin
            det_data = (c == 5) ? 64'h1 : ((c == 11) ? 64'h2 : 64'd0);
            step();
        end
        aresetn = 1'b0;
        det_data = 64'd0;
        step();
        aresetn = 1'b1;
        cyc = 0;
        check("rst_accum_tvalid", 128'(axis_bus.tvalid), 128'd0);
        check("rst_accum_lost", 128'(sts_lost), 128'd0);
        check("rst_accum_tdata", axis_bus.tdata, 128'd0);
        cfg_window = 8'd0;
        first_cyc = -1;
        first_data = '0;
        for (int c = 0; c < 25; c++) begin
            if (axis_bus.tvalid === 1'b1 && first_cyc < 0) begin
                first_cyc  = c;
                first_data = axis_bus.tdata;
            end
            det_data = (c == 7) ? 64'h8 : 64'd0;
            step();
        end
        check("rst_restart_cyc", 128'(first_cyc), 128'd15);
        check("rst_restart_data", first_data, {64'd7, 64'h8});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
